// File: rtl/tc_rr_arbiter4.sv
// ----------------------------------------------------------------------------
// tc_rr_arbiter4
//
// Four-way round-robin arbiter with zero-bubble handoff. The granted index is
// presented as {sel1,sel0} so it can drive a 2-to-4 decoder directly.
// "valid" is high while that index names an active grant.
//
// Search order starts one past the last granted requester and wraps 3->0.
// A holder that releases while still requesting therefore lands at the end
// of the order and is only re-granted after every other pending requester.
//
// Optional feature (macro TC_RR_ARBITER4_TIMEOUT_EN):
//   When defined, a 4-bit hold counter limits a continuous grant to 16
//   cycles. The forced release behaves exactly like a voluntary release and
//   produces a one-cycle "timeout" pulse. When undefined, there is no counter,
//   "timeout" is tied low and a grant lasts until it is released.
//
// Parameters:
//   UUID    - component identifier, no functional effect
//   NAME    - component label, no functional effect
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   req0..req3   in   request lines from requesters 0..3
//   done         in   current holder releases the grant
//   sel0, sel1   out  registered grant index {sel1,sel0}
//   valid        out  registered, 1 while a grant is active
//   timeout      out  registered one-cycle pulse on forced release
// ----------------------------------------------------------------------------
module tc_rr_arbiter4 #(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic done,
    output logic sel0,
    output logic sel1,
    output logic valid,
    output logic timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] sel_reg, sel_next;
    logic [1:0] last_reg, last_next;

    logic [3:0] req_vec;
    logic [1:0] cand_idx [4];
    logic [3:0] cand_req;

    logic       any_all, any_oth;
    logic [1:0] pick_all, pick_oth;
    logic       holder_req;
    logic       rel_req;
    logic       force_rel;
    logic       rel;

    // Identification parameters carry no function; fold them into a sink.
    logic unused_params;
    assign unused_params = (UUID == 0) ^ (NAME == "");

    assign req_vec = {req3, req2, req1, req0};

    // Candidate gi is the requester at distance gi+1 from LAST. Candidate 3
    // wraps around to LAST itself, which in GRANT is the current holder.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_req[gi] = req_vec[cand_idx[gi]];
        end
    endgenerate

    // First requester in search order, over all four candidates (IDLE) and
    // over the three that exclude the current holder (handoff in GRANT).
    // Iterating downward lets the nearest candidate win.
    always_comb begin
        any_all  = 1'b0;
        pick_all = last_reg;
        for (int i = 3; i >= 0; i--) begin
            if (cand_req[i]) begin
                any_all  = 1'b1;
                pick_all = cand_idx[i];
            end
        end
    end

    always_comb begin
        any_oth  = 1'b0;
        pick_oth = last_reg;
        for (int i = 2; i >= 0; i--) begin
            if (cand_req[i]) begin
                any_oth  = 1'b1;
                pick_oth = cand_idx[i];
            end
        end
    end

    // Dropping the request is treated the same as signalling done.
    assign holder_req = req_vec[sel_reg];
    assign rel_req    = done | ~holder_req;

`ifdef TC_RR_ARBITER4_TIMEOUT_EN
    logic [3:0] hold_cnt_reg;
    logic       timeout_reg;

    // Counts consecutive GRANT cycles without a release. Reaching 15 means
    // the grant has already been held for 16 cycles at the next edge.
    assign force_rel = (state_reg == GRANT) && !rel_req && (hold_cnt_reg == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= 4'd0;
            timeout_reg  <= 1'b0;
        end else begin
            if ((state_reg == GRANT) && !rel) begin
                hold_cnt_reg <= hold_cnt_reg + 4'd1;
            end else begin
                // Any release, new grant or idle cycle restarts the count.
                hold_cnt_reg <= 4'd0;
            end
            timeout_reg <= force_rel;
        end
    end

    assign timeout = timeout_reg;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign rel = rel_req | force_rel;

    // State, grant index and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            // LAST=3 makes requester 0 first in line after reset.
            last_reg  <= 2'd3;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                // done is meaningless without a holder and is not looked at.
                if (any_all) begin
                    state_next = GRANT;
                    sel_next   = pick_all;
                    last_next  = pick_all;
                end
            end
            GRANT: begin
                if (rel) begin
                    if (any_oth) begin
                        // Handoff on the same edge; valid never drops.
                        sel_next  = pick_oth;
                        last_next = pick_oth;
                    end else begin
                        // sel keeps the old index so the decoder input is stable.
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sel0  = sel_reg[0];
    assign sel1  = sel_reg[1];
    assign valid = (state_reg == GRANT);

endmodule

// File: tb/tb_tc_rr_arbiter4.sv
// ----------------------------------------------------------------------------
// tb_tc_rr_arbiter4
//
// Directed scenarios followed by randomized traffic. Every cycle the DUT is
// compared against a behavioural model that works with plain integers:
// a busy flag, the holder, the last granted index and a hold count.
// ----------------------------------------------------------------------------
module tb_tc_rr_arbiter4;

    logic clk = 1'b0;
    logic rst, req0, req1, req2, req3, done;
    logic sel0, sel1, valid, timeout;

    tc_rr_arbiter4 #(.UUID(7), .NAME("arb")) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .req2    (req2),
        .req3    (req3),
        .done    (done),
        .sel0    (sel0),
        .sel1    (sel1),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_last = 3;
    int m_cnt  = 0;
    bit m_tmo  = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // First index with a request at distance 1..span from last, or -1.
    function automatic int find_next(input logic [3:0] r, input int last, input int span);
        for (int k = 1; k <= span; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input bit d, input bit rs);
        int nxt;
        bit rel;
        bit forced;
        if (rs) begin
            m_busy = 1'b0; m_sel = 0; m_last = 3; m_cnt = 0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (!m_busy) begin
                nxt = find_next(r, m_last, 4);
                if (nxt >= 0) begin
                    m_busy = 1'b1; m_sel = nxt; m_last = nxt; m_cnt = 0;
                end
            end else begin
                rel    = d || !r[m_sel];
                forced = 1'b0;
`ifdef TC_RR_ARBITER4_TIMEOUT_EN
                if (!rel && m_cnt == 15) begin
                    rel    = 1'b1;
                    forced = 1'b1;
                end
`endif
                if (rel) begin
                    nxt = find_next(r, m_last, 3);
                    if (nxt >= 0) begin
                        m_sel = nxt; m_last = nxt;
                    end else begin
                        m_busy = 1'b0;
                    end
                    m_cnt = 0;
                    m_tmo = forced;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance the model, compare just after the edge.
    task automatic cyc(input logic [3:0] r, input bit d, input bit rs);
        logic [3:0] dec;
        {req3, req2, req1, req0} = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
        dec = 4'b0001 << {sel1, sel0};
        check_eq("valid", int'(valid), int'(m_busy));
        check_eq("sel", int'({sel1, sel0}), m_sel);
        check_eq("timeout", int'(timeout), int'(m_tmo));
        if (m_busy) check_eq("decoder", int'(dec), 1 << m_sel);
    endtask

    initial begin
        logic [3:0] r;
        bit d, rs;
        int exp_seq [5] = '{0, 1, 2, 3, 0};

        {req3, req2, req1, req0} = 4'b0000;
        done = 1'b0;
        rst  = 1'b1;

        // Reset state
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b1111, 1'b0, 1'b1);
        check_eq("rst_sel", int'({sel1, sel0}), 0);
        check_eq("rst_valid", int'(valid), 0);

        // All requesting, done pulsed after each grant: 0,1,2,3,0
        cyc(4'b1111, 1'b0, 1'b0);
        check_eq("rr_first", int'({sel1, sel0}), exp_seq[0]);
        for (int i = 1; i < 5; i++) begin
            cyc(4'b1111, 1'b1, 1'b0);
            check_eq("rr_seq", int'({sel1, sel0}), exp_seq[i]);
            check_eq("rr_valid", int'(valid), 1);
            cyc(4'b1111, 1'b0, 1'b0);
        end

        // Single requester 2, then drop it
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0100, 1'b0, 1'b0);
        check_eq("r2_sel", int'({sel1, sel0}), 2);
        check_eq("r2_valid", int'(valid), 1);
        cyc(4'b0000, 1'b0, 1'b0);
        check_eq("r2_drop_valid", int'(valid), 0);
        check_eq("r2_drop_sel", int'({sel1, sel0}), 2);

        // done in IDLE is ignored
        cyc(4'b0000, 1'b1, 1'b0);
        check_eq("idle_done", int'(valid), 0);

        // Holder 1 hands to 3 on the same edge
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 1'b0);
        check_eq("h1_sel", int'({sel1, sel0}), 1);
        cyc(4'b1010, 1'b1, 1'b0);
        check_eq("handoff_sel", int'({sel1, sel0}), 3);
        check_eq("handoff_valid", int'(valid), 1);

        // Reset mid-grant, then first grant goes to 0
        cyc(4'b1111, 1'b0, 1'b1);
        check_eq("midrst_sel", int'({sel1, sel0}), 0);
        check_eq("midrst_valid", int'(valid), 0);
        cyc(4'b1111, 1'b0, 1'b0);
        check_eq("post_rst_grant", int'({sel1, sel0}), 0);
        check_eq("post_rst_valid", int'(valid), 1);

        // Sole requester holding without done
        cyc(4'b0000, 1'b0, 1'b1);
`ifdef TC_RR_ARBITER4_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            cyc(4'b0001, 1'b0, 1'b0);
            check_eq("hold_valid", int'(valid), 1);
            check_eq("hold_tmo", int'(timeout), 0);
        end
        cyc(4'b0001, 1'b0, 1'b0);
        check_eq("tmo_pulse", int'(timeout), 1);
        check_eq("tmo_valid", int'(valid), 0);
        cyc(4'b0001, 1'b0, 1'b0);
        check_eq("tmo_regrant", int'(valid), 1);
        check_eq("tmo_clear", int'(timeout), 0);
`else
        for (int i = 0; i < 100; i++) begin
            cyc(4'b0001, 1'b0, 1'b0);
            check_eq("hold_valid", int'(valid), 1);
            check_eq("hold_tmo", int'(timeout), 0);
        end
`endif

        // Randomized traffic; requests mostly persist so grants are held
        r = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            d  = ($urandom_range(5) == 0);
            rs = ($urandom_range(149) == 0);
            cyc(r, d, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
